stream_rr_arbiter: RTL
======================

# stream_rr_arbiter

Packet-level round-robin arbiter that shares one downstream video-processing stage (e.g. the YUV→RGB colour-conversion chain) between NUM_SRC AXI-stream requesters. Each source's grant is held for a whole packet (through the `t_last` beat), so packets are never interleaved. The output beat carries the winning source index on `dst_dest`. The block sits between the DMA-side stream sources and the processing-chain crossbar input.

## Interface
Parameters:
- NUM_SRC, 4, number of requesting streams (1..16)
- DATA_WIDTH, 64, beat data width in bits
- USER_WIDTH, 1, sideband user width
- DEST_WIDTH, 4, dst_dest width; must satisfy 2**DEST_WIDTH ≥ NUM_SRC

Ports:
- aclk  in  1  clock
- areset  in  1  reset; one clock; reset is synchronous and active-high
- src_en  in  NUM_SRC  per-source arbitration enable
- src_valid  in  NUM_SRC  per-source t_valid
- src_ready  out  NUM_SRC  per-source t_ready
- src_data  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- src_last  in  NUM_SRC  per-source t_last
- src_user  in  NUM_SRC*USER_WIDTH  per-source t_user, packed like src_data
- dst_valid  out  1  output t_valid
- dst_ready  in  1  output t_ready
- dst_data  out  DATA_WIDTH  output beat
- dst_last  out  1  output t_last
- dst_user  out  USER_WIDTH  output t_user
- dst_dest  out  DEST_WIDTH  index of the source that produced the beat
- busy  out  1  high while a packet is locked
- grant_idx  out  DEST_WIDTH  currently or last granted source

## Operation
- States:
  - IDLE: no grant.
  - LOCKED: grant register `g` is valid.
- IDLE→LOCKED: when any `src_valid[i] & src_en[i]` is high. `g` is set to the first requesting index strictly after the round-robin pointer `ptr`, searching upward modulo NUM_SRC.
- In IDLE, all `src_ready` are 0.
- In LOCKED, `src_ready[g] = !dst_valid || dst_ready`. All other `src_ready` are 0.
- Accepted beat (`src_valid[g] & src_ready[g]`): the output register loads data, last, user, and `dst_dest = g`, and sets `dst_valid`.
- Accepted beat with `src_last[g]=1`: LOCKED→IDLE and `ptr <= g`.
- A dst handshake without a new load clears `dst_valid`.
- `src_en` is sampled only in IDLE. Deasserting `src_en[g]` mid-packet does not break the lock.
- If `src_valid[g]` drops mid-packet, the lock is held and the block waits; no other source is granted.
- `busy` = (state == LOCKED).
- `grant_idx` = `g`, which holds its value in IDLE.
- NUM_SRC=1 degenerates to a pass-through with one bubble per packet.

## Timing
- Reset values:
  - state IDLE
  - `ptr` = NUM_SRC-1, so source 0 wins first
  - `g` = 0
  - `dst_valid`, `dst_last`, `dst_data`, `dst_user`, `dst_dest` = 0
  - `src_ready` = 0, `busy` = 0, `grant_idx` = 0
- Reset asserted mid-packet:
  - the in-flight packet and output beat are discarded
  - the next packet from any source starts a fresh arbitration
- Arbitration takes 1 cycle. If `src_valid` rises in cycle T (in IDLE), `busy` is 1 in T+1.
- The first beat can be accepted in T+1 and appears on `dst_valid` in T+2.
- Within a packet, throughput is 1 beat/cycle while `dst_ready`=1.
- There is exactly one idle cycle between the last beat of one packet and the first acceptance of the next.
- `src_ready[g]` depends combinationally on `dst_ready`. `dst_*` are fully registered.
- Output stall (`dst_ready`=0 with `dst_valid`=1): `src_ready[g]`=0 and all `dst_*` are held stable.
- Simultaneous dst handshake and new load in the same cycle: the new beat replaces the old one and `dst_valid` stays 1.
- A single-beat packet (first beat has `src_last`=1) returns to IDLE the cycle after acceptance.

## Test plan
- Reset, all sources valid, all enabled, 2-beat packets with data = {src, beat} → `dst_dest` order 0,1,2,3,0; each packet's beats contiguous; one bubble between packets.
- Source 2 only, packet of 5 beats with `dst_ready` toggling 1,0,0,1,… → all 5 beats delivered in order with `dst_dest`=2, no duplicate or lost beat, `dst_*` stable while stalled.
- Source 1 locked; source 1 drops `src_valid` for 3 cycles mid-packet while source 3 is valid → no beat from source 3 until source 1's `t_last` is accepted, then source 3 is granted.
- `src_en`=4'b1010 with all valid → only sources 1 and 3 alternate. Clearing `src_en[1]` mid-packet lets the packet finish, then only source 3 is granted.
- Single-beat packets on sources 0 and 3 with `dst_ready`=1 → `dst_dest` 0 then 3, `dst_last`=1 on each, 2-cycle spacing.
- `areset` pulsed on the third beat of a 6-beat packet → `dst_valid`=0 the next cycle; the next arbitration grants the lowest requesting index.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter: shares one AXI-stream sink between NUM_SRC sources.
// A grant is held from the first beat through t_last, so packets are never interleaved.
module stream_rr_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned DEST_WIDTH = 4
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [NUM_SRC-1:0]               src_en,
  input  logic [NUM_SRC-1:0]               src_valid,
  output logic [NUM_SRC-1:0]               src_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]    src_data,
  input  logic [NUM_SRC-1:0]               src_last,
  input  logic [NUM_SRC*USER_WIDTH-1:0]    src_user,
  output logic                             dst_valid,
  input  logic                             dst_ready,
  output logic [DATA_WIDTH-1:0]            dst_data,
  output logic                             dst_last,
  output logic [USER_WIDTH-1:0]            dst_user,
  output logic [DEST_WIDTH-1:0]            dst_dest,
  output logic                             busy,
  output logic [DEST_WIDTH-1:0]            grant_idx
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        g;
  logic [IDX_W-1:0]        nxt_g;
  logic [NUM_SRC-1:0]      req;
  logic                    sel_valid;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [USER_WIDTH-1:0]   sel_user;
  logic                    out_free;
  logic                    accept;

  // Mux the granted source onto a single beat
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_user  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (IDX_W'(i) == g) begin
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        sel_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_user  = src_user[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  // First requester strictly after ptr, wrapping modulo NUM_SRC
  always_comb begin
    logic        found;
    int unsigned idx;
    req   = src_valid & src_en;
    nxt_g = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
        if (!found && (j == idx) && req[j]) begin
          found = 1'b1;
          nxt_g = IDX_W'(j);
        end
      end
    end
  end

  assign out_free = !dst_valid || dst_ready;
  assign accept   = (state == LOCKED) && sel_valid && out_free;

  always_comb begin
    src_ready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (state == LOCKED) && (IDX_W'(i) == g) && out_free;
    end
  end

  assign busy      = (state == LOCKED);
  assign grant_idx = DEST_WIDTH'(g);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      ptr       <= IDX_W'(NUM_SRC - 1);
      g         <= '0;
      dst_valid <= 1'b0;
      dst_data  <= '0;
      dst_last  <= 1'b0;
      dst_user  <= '0;
      dst_dest  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            g     <= nxt_g;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && sel_last) begin
            state <= IDLE;
            ptr   <= g;
          end
        end
        default: state <= IDLE;
      endcase

      // Output register: a new load replaces any beat being handed off this cycle
      if (accept) begin
        dst_valid <= 1'b1;
        dst_data  <= sel_data;
        dst_last  <= sel_last;
        dst_user  <= sel_user;
        dst_dest  <= DEST_WIDTH'(g);
      end else if (dst_ready) begin
        dst_valid <= 1'b0;
      end
    end
  end

endmodule
